lz77_stream_encoder: RTL and testbench

LZ77_STREAM_ENCODER -- requirements
Module: lz77_stream_encoder

---
 rtl/lz77_stream_encoder_if.sv | 25 ++
 rtl/lz77_stream_encoder.sv | 170 +++++++++++++++++
 tb/tb_lz77_stream_encoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_stream_encoder_if.sv
// Stream bundle for the LZ77 encoder: symbol input, tuple output and end-of-stream pulse.
interface lz77_stream_encoder_if #(
    parameter int CHAR_W = 8
);
    logic [CHAR_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        offset;
    logic [4:0]        match_len;
    logic [CHAR_W-1:0] char_nxt;
    logic              finish;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_valid, offset, match_len, char_nxt, finish
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_valid, offset, match_len, char_nxt, finish
    );
endinterface

// File: rtl/lz77_stream_encoder.sv
// LZ77 encoder: fills a lookahead buffer, scans one history offset per cycle for the
// longest match, emits (offset, match_len, char_nxt) and slides matched symbols into history.
module lz77_stream_encoder #(
    parameter int                CHAR_W     = 8,
    parameter int                SEARCH_LEN = 30,
    parameter int                LA_LEN     = 24,
    parameter logic [CHAR_W-1:0] END_CHAR   = 8'h24
) (
    input logic                  clk,
    input logic                  reset,
    lz77_stream_encoder_if.slave s
);
    localparam int SW = $clog2(SEARCH_LEN);
    localparam int LW = $clog2(LA_LEN);

    typedef enum logic [2:0] {S_FILL, S_SEARCH, S_EMIT, S_SHIFT, S_DONE} state_t;

    state_t            r_state;
    logic [5:0]        r_lcnt;
    logic [5:0]        r_hcnt;
    logic              r_last;
    logic [4:0]        r_cand;
    logic [4:0]        r_best_off;
    logic [4:0]        r_best_len;
    logic [5:0]        r_shift_left;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_finish;
    logic [4:0]        r_offset;
    logic [4:0]        r_match_len;
    logic [CHAR_W-1:0] r_char_nxt;

    // r_hist[0] is the most recent symbol; r_la[0] is the next symbol to encode.
    logic [CHAR_W-1:0] r_hist [SEARCH_LEN];
    logic [CHAR_W-1:0] r_la   [LA_LEN];

    logic              w_take;
    logic [5:0]        w_fill_cnt;
    logic              w_fill_last;
    logic [5:0]        w_cap;
    logic [4:0]        w_len;
    logic              w_run;
    logic [CHAR_W-1:0] w_src;
    logic              w_upd;
    logic [4:0]        w_best_off_n;
    logic [4:0]        w_best_len_n;
    logic [CHAR_W-1:0] w_char;
    logic [5:0]        w_len1;
    logic [5:0]        w_shift_n;

    assign w_take      = s.in_valid & r_in_ready;
    assign w_fill_cnt  = r_lcnt + {5'd0, w_take};
    assign w_fill_last = r_last | (w_take & s.in_last);
    assign w_cap       = r_last ? r_lcnt : r_lcnt - 6'd1;

    // Sources at or beyond the current position come from the lookahead, so matches may overlap.
    always_comb begin
        w_len = '0;
        w_run = 1'b1;
        w_src = '0;
        for (int j = 0; j < LA_LEN; j++) begin
            if (int'(r_cand) >= j) w_src = r_hist[SW'(int'(r_cand) - j)];
            else                   w_src = r_la[LW'(j - int'(r_cand) - 1)];
            if (w_run && (j < int'(w_cap)) && (w_src == r_la[LW'(j)])) w_len = w_len + 5'd1;
            else                                                      w_run = 1'b0;
        end
    end

    assign w_upd        = ({1'b0, r_cand} < r_hcnt) && (w_len >= r_best_len);
    assign w_best_off_n = w_upd ? r_cand : r_best_off;
    assign w_best_len_n = w_upd ? w_len  : r_best_len;
    assign w_char       = ({1'b0, w_best_len_n} < r_lcnt) ? r_la[LW'(w_best_len_n)] : END_CHAR;
    assign w_len1       = {1'b0, r_match_len} + 6'd1;
    assign w_shift_n    = (w_len1 < r_lcnt) ? w_len1 : r_lcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_lcnt       <= '0;
            r_hcnt       <= '0;
            r_last       <= 1'b0;
            r_cand       <= '0;
            r_best_off   <= '0;
            r_best_len   <= '0;
            r_shift_left <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_finish     <= 1'b0;
            r_offset     <= '0;
            r_match_len  <= '0;
            r_char_nxt   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_lcnt <= w_fill_cnt;
                    r_last <= w_fill_last;
                    if (w_fill_cnt == 6'(LA_LEN) || (w_fill_last && w_fill_cnt != 6'd0)) begin
                        r_state    <= S_SEARCH;
                        r_in_ready <= 1'b0;
                        r_cand     <= 5'(SEARCH_LEN - 1);
                        r_best_off <= '0;
                        r_best_len <= '0;
                    end else begin
                        r_in_ready <= ~w_fill_last;
                    end
                end
                S_SEARCH: begin
                    r_best_off <= w_best_off_n;
                    r_best_len <= w_best_len_n;
                    if (r_cand == 5'd0) begin
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                        r_offset    <= w_best_off_n;
                        r_match_len <= w_best_len_n;
                        r_char_nxt  <= w_char;
                    end else begin
                        r_cand <= r_cand - 5'd1;
                    end
                end
                S_EMIT: begin
                    if (s.out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_shift_left <= w_shift_n;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_lcnt       <= r_lcnt - 6'd1;
                    r_hcnt       <= (r_hcnt == 6'(SEARCH_LEN)) ? r_hcnt : r_hcnt + 6'd1;
                    r_shift_left <= r_shift_left - 6'd1;
                    if (r_shift_left == 6'd1) begin
                        if (r_lcnt == 6'd1 && r_last) begin
                            r_state  <= S_DONE;
                            r_finish <= 1'b1;
                        end else begin
                            r_state    <= S_FILL;
                            r_in_ready <= ~r_last;
                        end
                    end
                end
                S_DONE: begin
                    r_finish   <= 1'b0;
                    r_hcnt     <= '0;
                    r_lcnt     <= '0;
                    r_last     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    // Symbol storage carries no reset; the counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL && w_take) r_la[LW'(r_lcnt)] <= s.in_data;
        if (r_state == S_SHIFT) begin
            r_hist[0] <= r_la[0];
            for (int k = 1; k < SEARCH_LEN; k++) r_hist[k] <= r_hist[k-1];
            for (int k = 0; k < LA_LEN - 1; k++) r_la[k] <= r_la[k+1];
        end
    end

    assign s.in_ready  = r_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.offset    = r_offset;
    assign s.match_len = r_match_len;
    assign s.char_nxt  = r_char_nxt;
    assign s.finish    = r_finish;
endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Testbench for lz77_stream_encoder: directed tuple sequences plus random streams
// compared against a plain LZ77 reference model.
module tb_lz77_stream_encoder;
    localparam int SL = 30;
    localparam int LA = 24;
    localparam logic [7:0] ENDC = 8'h24;

    typedef struct packed {
        logic [4:0] off;
        logic [4:0] len;
        logic [7:0] ch;
    } tup_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] stim[$];
    tup_t       act[$];
    tup_t       exp_q[$];

    lz77_stream_encoder_if #(.CHAR_W(8)) bus ();

    lz77_stream_encoder #(.CHAR_W(8), .SEARCH_LEN(SL), .LA_LEN(LA), .END_CHAR(ENDC)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_stim(input string str);
        stim.delete();
        for (int i = 0; i < str.len(); i++) stim.push_back(str[i]);
    endtask

    task automatic add_exp(input int o, input int l, input logic [7:0] c);
        tup_t t;
        t.off = 5'(o);
        t.len = 5'(l);
        t.ch  = c;
        exp_q.push_back(t);
    endtask

    // Greedy LZ77 over the whole stream: longest match within the last SL symbols,
    // capped by what the lookahead holds, smallest offset on ties.
    task automatic build_exp();
        int n, p, cnt, cap, h, bl, bo, l;
        bit lastin;
        exp_q.delete();
        n = stim.size();
        p = 0;
        while (p < n) begin
            cnt    = (n - p < LA) ? n - p : LA;
            lastin = (p + cnt == n);
            cap    = lastin ? cnt : cnt - 1;
            h      = (p < SL) ? p : SL;
            bl     = -1;
            bo     = 0;
            for (int o = 0; o < h; o++) begin
                l = 0;
                while (l < cap && stim[p - 1 - o + l] == stim[p + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bo = o;
                end
            end
            if (bl < 0) bl = 0;
            add_exp(bo, bl, (bl < cnt) ? stim[p + bl] : ENDC);
            p += (bl + 1 < cnt) ? bl + 1 : cnt;
        end
    endtask

    task automatic run(input int max_cyc, input bit gaps, input bit stall, output bit fin);
        int   sent;
        int   stalls;
        tup_t held;
        tup_t cur;
        sent   = 0;
        stalls = 0;
        fin    = 1'b0;
        held   = '0;
        act.delete();
        for (int c = 0; c < max_cyc && !fin; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.in_last   = 1'b0;
            bus.out_ready = 1'b0;
            if (bus.finish) begin
                fin = 1'b1;
            end else begin
                if (bus.in_ready && sent < stim.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = stim[sent];
                    bus.in_last  = (sent == stim.size() - 1);
                    sent++;
                end
                cur = {bus.offset, bus.match_len, bus.char_nxt};
                if (stall && stalls == 6) begin
                    chk("stall_release_valid", bus.out_valid, 1'b0);
                    stalls++;
                end else if (stall && stalls > 0 && stalls < 6) begin
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk("stall_hold", cur, held);
                    if (stalls == 5) begin
                        bus.out_ready = 1'b1;
                        act.push_back(cur);
                    end
                    stalls++;
                end else if (bus.out_valid) begin
                    if (stall && stalls == 0) begin
                        held = cur;
                        stalls++;
                    end else if (!gaps || $urandom_range(0, 2) != 0) begin
                        bus.out_ready = 1'b1;
                        act.push_back(cur);
                    end
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s_count", tag), act.size(), exp_q.size());
        for (int i = 0; i < act.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_tuple%0d", tag, i), act[i], exp_q[i]);
    endtask

    task automatic do_stream(input string tag, input bit gaps, input bit stall);
        bit fin;
        run(20000, gaps, stall, fin);
        chk($sformatf("%s_finish_seen", tag), fin, 1'b1);
        compare(tag);
        @(posedge clk);
        #1;
        chk($sformatf("%s_finish_pulse", tag), bus.finish, 1'b0);
        chk($sformatf("%s_ready_after", tag), bus.in_ready, 1'b1);
    endtask

    initial begin
        bit fin;
        int n;
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_finish", bus.finish, 1'b0);
        chk("rst_offset", bus.offset, 5'd0);
        chk("rst_match_len", bus.match_len, 5'd0);
        chk("rst_char_nxt", bus.char_nxt, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        set_stim("aaaa");
        exp_q.delete();
        add_exp(0, 0, 8'h61);
        add_exp(0, 3, ENDC);
        do_stream("aaaa", 1'b0, 1'b0);

        set_stim("abab");
        exp_q.delete();
        add_exp(0, 0, 8'h61);
        add_exp(0, 0, 8'h62);
        add_exp(1, 2, ENDC);
        do_stream("abab", 1'b0, 1'b0);

        stim.delete();
        for (int i = 0; i < 60; i++) stim.push_back(8'h78);
        exp_q.delete();
        add_exp(0, 0, 8'h78);
        add_exp(0, 23, 8'h78);
        add_exp(0, 23, 8'h78);
        add_exp(0, 11, ENDC);
        do_stream("x60", 1'b0, 1'b0);

        set_stim("q");
        exp_q.delete();
        add_exp(0, 0, 8'h71);
        do_stream("single_q", 1'b0, 1'b0);

        set_stim("aaaa");
        exp_q.delete();
        add_exp(0, 0, 8'h61);
        add_exp(0, 3, ENDC);
        do_stream("backpressure", 1'b0, 1'b1);

        // Abort "abab" while its first search is in progress.
        set_stim("abab");
        run(8, 1'b0, 1'b0, fin);
        chk("mid_search_in_ready", bus.in_ready, 1'b0);
        chk("mid_search_out_valid", bus.out_valid, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_match_len", bus.match_len, 5'd0);
        chk("midrst_char_nxt", bus.char_nxt, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        set_stim("ab");
        exp_q.delete();
        add_exp(0, 0, 8'h61);
        add_exp(0, 0, 8'h62);
        do_stream("after_reset", 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            n = (t == 5) ? 80 : $urandom_range(1, 80);
            stim.delete();
            for (int i = 0; i < n; i++)
                stim.push_back(8'h61 + 8'((t == 0) ? 0 : $urandom_range(0, 2)));
            build_exp();
            do_stream($sformatf("rand%0d", t), t[0], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
